keypad_matrix_scanner: RTL and testbench
========================================

Name: keypad_matrix_scanner

Overview:
Parametrised successor to the fixed 4x4 keyboard scanner. Scans an N_ROWS x N_COLS key matrix by driving columns active-low one at a time and reading the rows, which are active-low and pulled up. Debounces both press and release, reports a key code with a one-cycle valid strobe and a held level, and flags multi-key ghosting. Sits between the keypad pins and the charger control FSM (coin/amount/confirm entry).

Parameters:
N_ROWS, 4, number of row inputs
N_COLS, 4, number of column outputs
SCAN_DWELL, 4, clocks each column is driven before rows are sampled (must be >=3)
DEBOUNCE_CYCLES, 20, stable-press clocks before a key is accepted (20 ms at 1 kHz)
RELEASE_CYCLES, 20, stable-release clocks before press drops
REPEAT_DELAY, 1000, clocks from first key_valid to first auto-repeat (feature only)
REPEAT_PERIOD, 200, clocks between auto-repeats (feature only)

Ports:
clk  input  1  system clock (1 kHz nominal)
rst  input  1  asynchronous, active-high reset
row  input  N_ROWS  raw row lines, active-low, asynchronous to clk
col  output  N_COLS  column drive, one-hot-low, registered
key_value  output  $clog2(N_ROWS*N_COLS)  code = r*N_COLS + c; r = row index, c = column index, bit 0 = index 0
key_valid  output  1  one-cycle strobe when key_value is newly accepted
press  output  1  high from acceptance until release is debounced
multi_key  output  1  high with key_valid if >1 row was low at detection

Behaviour:
- Reset (async): col = all ones, key_value = 0, key_valid = 0, press = 0, multi_key = 0, column index = 0, FSM = SCAN, synchroniser = all ones.
- row passes a 2-FF synchroniser, giving 2 clocks of latency. All decisions use the synchronised value rs.
- SCAN: drive col[c] low and all other columns high. Dwell counter runs 0..SCAN_DWELL-1. On the last dwell clock, sample rs:
  - If all ones: c <= (c == N_COLS-1) ? 0 : c+1.
  - Otherwise: latch c, latched row pattern P = rs, and r = lowest low bit. Set the multi flag if more than one bit is low. Go to DEBOUNCE; col stays frozen.
- DEBOUNCE: count clocks while rs == P.
  - If rs != P: abandon without output and return to SCAN at c+1.
  - When the count reaches DEBOUNCE_CYCLES: assert key_valid for 1 clock, load key_value and multi_key, set press = 1, go to HELD.
- HELD: col stays frozen.
  - If rs == all ones: go to RELEASE with the counter cleared.
  - Other row changes are ignored.
- RELEASE:
  - If rs != all ones: return to HELD; the repeat timer is not reset.
  - When the count reaches RELEASE_CYCLES: press = 0, multi_key = 0, return to SCAN at c+1.
- key_value holds its last code until the next acceptance.
- At most one key_valid per clock.
- Counters are sized $clog2(max+1) and saturate; none of them wrap.
- A reset asserted mid-operation aborts immediately and the scan restarts at column 0.

Optional Feature:
KEYPAD_AUTOREPEAT_EN.
- Defined: in HELD or RELEASE, a repeat timer starts at the first key_valid. Another key_valid with the same key_value pulses REPEAT_DELAY clocks later, then every REPEAT_PERIOD clocks while press = 1. The timer clears when press drops.
- Undefined: the timer and parameters are unused, and there is exactly one key_valid per press.

Decomposition:
- Shared package keypad_pkg holds:
  - state encoding SCAN/DEBOUNCE/HELD/RELEASE
  - the code-width function clog2(N_ROWS*N_COLS)
  - lowest-zero-index and popcount functions
- One sub-module, keypad_row_sync: a parametrised N-bit 2-FF synchroniser that resets to ones.

Test Plan:
1. Hold rst = 1 -> col = 4'b1111, press = 0, key_value = 0. Release rst -> col = 4'b1110 at the next clk, then rotates 1101, 1011, 0111 every 4 clocks.
2. Drive row = 4'b0111 whenever col = 4'b1110 -> one key_valid, key_value = 12, press = 1, DEBOUNCE_CYCLES after detection. Release -> press = 0 after 20 clocks, and scanning resumes at col = 4'b1101.
3. Bounce: row = 4'b0111 on col0 for 10 clocks, then released -> no key_valid, press stays 0, scanning continues.
4. Long hold on col2/row3 (key_value = 14), released 3900 clocks after the first key_valid:
   - Macro undefined: 1 key_valid.
   - Macro defined: 16 key_valid (initial + repeats at +1000, +1200, ..., +3800).
5. row = 4'b0110 while col = 4'b1101 -> key_value = 1, multi_key = 1 together with key_valid.
6. Assert rst during HELD -> press = 0 and col = 4'b1111 in the same cycle, without waiting for clk. After release, the scan restarts at col = 4'b1110 and no spurious key_valid occurs.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad matrix scanner: FSM state encoding,
// key-code width and row-pattern decode functions.
package keypad_pkg;

    typedef enum logic [1:0] {
        st_scan,
        st_debounce,
        st_held,
        st_release
    } kp_state_t;

    function automatic int code_width(input int n_rows, input int n_cols);
        return (n_rows * n_cols > 1) ? $clog2(n_rows * n_cols) : 1;
    endfunction

    // Rows are active-low, so a pressed key shows up as a zero bit.
    function automatic int lowest_zero(input logic [31:0] v, input int n);
        int idx;
        idx = 0;
        for (int i = n - 1; i >= 0; i--) begin
            if (!v[i[4:0]]) idx = i;
        end
        return idx;
    endfunction

    function automatic int count_zeros(input logic [31:0] v, input int n);
        int z;
        z = 0;
        for (int i = 0; i < n; i++) begin
            if (!v[i[4:0]]) z++;
        end
        return z;
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// N-bit two-flop synchroniser for the raw row lines; resets to all ones
// (the idle level of the pulled-up rows).
module keypad_row_sync
    import keypad_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= '1;
            q    <= '1;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/keypad_matrix_scanner.sv
// Keypad matrix scanner with press/release debounce and ghosting flag.
// Optional auto-repeat is enabled by defining KEYPAD_AUTOREPEAT_EN.
//
// state       | meaning
// st_scan     | drive one column low, dwell, sample rows
// st_debounce | column frozen, pattern must stay stable DEBOUNCE_CYCLES
// st_held     | key accepted, waiting for all rows to go idle
// st_release  | rows idle, must stay idle RELEASE_CYCLES
module keypad_matrix_scanner
    import keypad_pkg::*;
#(
    parameter int N_ROWS          = 4,
    parameter int N_COLS          = 4,
    parameter int SCAN_DWELL      = 4,
    parameter int DEBOUNCE_CYCLES = 20,
    parameter int RELEASE_CYCLES  = 20,
    parameter int REPEAT_DELAY    = 1000,
    parameter int REPEAT_PERIOD   = 200
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [N_ROWS-1:0]                      row,
    output logic [N_COLS-1:0]                      col,
    output logic [code_width(N_ROWS, N_COLS)-1:0]  key_value,
    output logic                                   key_valid,
    output logic                                   press,
    output logic                                   multi_key
);

    localparam int KW      = code_width(N_ROWS, N_COLS);
    localparam int CW      = (N_COLS > 1) ? $clog2(N_COLS) : 1;
    localparam int RW      = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
    localparam int DW      = $clog2(SCAN_DWELL);
    localparam int CNT_MAX = (DEBOUNCE_CYCLES > RELEASE_CYCLES) ? DEBOUNCE_CYCLES : RELEASE_CYCLES;
    localparam int CNTW    = $clog2(CNT_MAX + 1);
    localparam logic [N_ROWS-1:0] ROWS_IDLE = '1;

    function automatic logic [N_COLS-1:0] col_drive(input logic [CW-1:0] idx);
        return ~(N_COLS'(1) << idx);
    endfunction

    kp_state_t          state;
    logic [N_ROWS-1:0]  rs;
    logic [N_ROWS-1:0]  pat;
    logic [CW-1:0]      c;
    logic [CW-1:0]      c_next;
    logic [RW-1:0]      r;
    logic               multi;
    logic [DW-1:0]      dwell;
    logic [CNTW-1:0]    cnt;
    logic [CNTW-1:0]    cnt_inc;
    logic               release_done;

    keypad_row_sync #(.N(N_ROWS)) u_row_sync (
        .clk (clk),
        .rst (rst),
        .d   (row),
        .q   (rs)
    );

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int REPW    = $clog2(REP_MAX + 1);

    logic [REPW-1:0] rep_cnt;
    logic [REPW-1:0] rep_inc;
    logic            rep_first;
    logic            rep_fire;
`else
    logic unused_repeat;
    assign unused_repeat = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD)};
`endif

    always_comb begin
        c_next       = (c == CW'(N_COLS - 1)) ? '0 : c + 1'b1;
        cnt_inc      = (cnt == CNTW'(CNT_MAX)) ? cnt : cnt + 1'b1;
        release_done = (state == st_release) && (rs == ROWS_IDLE)
                       && (cnt_inc == CNTW'(RELEASE_CYCLES));
`ifdef KEYPAD_AUTOREPEAT_EN
        rep_inc  = (rep_cnt == REPW'(REP_MAX)) ? rep_cnt : rep_cnt + 1'b1;
        rep_fire = rep_first ? (rep_inc == REPW'(REPEAT_DELAY))
                             : (rep_inc == REPW'(REPEAT_PERIOD));
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= st_scan;
            c         <= '0;
            col       <= '1;
            dwell     <= '0;
            cnt       <= '0;
            pat       <= '1;
            r         <= '0;
            multi     <= 1'b0;
            key_value <= '0;
            key_valid <= 1'b0;
            press     <= 1'b0;
            multi_key <= 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
            rep_cnt   <= '0;
            rep_first <= 1'b0;
`endif
        end else begin
            key_valid <= 1'b0;
            case (state)
                st_scan: begin
                    // all-ones col only occurs straight after reset: start the dwell cleanly
                    if (col == '1) begin
                        col   <= col_drive(c);
                        dwell <= '0;
                    end else if (dwell == DW'(SCAN_DWELL - 1)) begin
                        dwell <= '0;
                        if (rs == ROWS_IDLE) begin
                            c   <= c_next;
                            col <= col_drive(c_next);
                        end else begin
                            pat   <= rs;
                            r     <= RW'(lowest_zero(32'(rs), N_ROWS));
                            multi <= (count_zeros(32'(rs), N_ROWS) > 1);
                            cnt   <= '0;
                            state <= st_debounce;
                        end
                    end else begin
                        dwell <= dwell + 1'b1;
                    end
                end
                st_debounce: begin
                    if (rs != pat) begin
                        c     <= c_next;
                        col   <= col_drive(c_next);
                        dwell <= '0;
                        state <= st_scan;
                    end else if (cnt_inc == CNTW'(DEBOUNCE_CYCLES)) begin
                        key_valid <= 1'b1;
                        key_value <= KW'(int'(r) * N_COLS + int'(c));
                        multi_key <= multi;
                        press     <= 1'b1;
                        cnt       <= '0;
                        state     <= st_held;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                st_held: begin
                    if (rs == ROWS_IDLE) begin
                        cnt   <= '0;
                        state <= st_release;
                    end
                end
                st_release: begin
                    if (rs != ROWS_IDLE) begin
                        state <= st_held;
                    end else if (release_done) begin
                        press     <= 1'b0;
                        multi_key <= 1'b0;
                        cnt       <= '0;
                        c         <= c_next;
                        col       <= col_drive(c_next);
                        dwell     <= '0;
                        state     <= st_scan;
                    end else begin
                        cnt <= cnt_inc;
                    end
                end
                default: state <= st_scan;
            endcase
`ifdef KEYPAD_AUTOREPEAT_EN
            // press is only high in held/release, so the timer runs exactly there
            if (state == st_debounce) begin
                rep_cnt   <= '0;
                rep_first <= 1'b1;
            end else if (release_done || !press) begin
                rep_cnt   <= '0;
                rep_first <= 1'b0;
            end else if (rep_fire) begin
                key_valid <= 1'b1;
                rep_cnt   <= '0;
                rep_first <= 1'b0;
            end else begin
                rep_cnt <= rep_inc;
            end
`endif
        end
    end

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Self-checking bench for keypad_matrix_scanner with a keypad pin model and
// a key_valid scoreboard (honours KEYPAD_AUTOREPEAT_EN).
module tb_keypad_matrix_scanner;

    localparam int SCAN_DWELL      = 4;
    localparam int DEBOUNCE_CYCLES = 20;
    localparam int RELEASE_CYCLES  = 20;
`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int LONG_HOLD_VALIDS = 16;
`else
    localparam int LONG_HOLD_VALIDS = 1;
`endif

    typedef struct {
        int   code;
        logic multi;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_value;
    logic       key_valid;
    logic       press;
    logic       multi_key;

    logic       key_on   = 1'b0;
    logic [1:0] key_c    = 2'd0;
    logic [3:0] key_mask = 4'b1111;

    exp_t exp_q[$];
    int   errors   = 0;
    int   checks   = 0;
    int   kv_count = 0;

    // Physical keypad: the pressed rows pull low only while their column is driven low.
    assign row = (key_on && col[key_c] == 1'b0) ? key_mask : 4'b1111;

    always #5 clk = ~clk;

    keypad_matrix_scanner #(
        .N_ROWS          (4),
        .N_COLS          (4),
        .SCAN_DWELL      (SCAN_DWELL),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .RELEASE_CYCLES  (RELEASE_CYCLES),
        .REPEAT_DELAY    (1000),
        .REPEAT_PERIOD   (200)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .row       (row),
        .col       (col),
        .key_value (key_value),
        .key_valid (key_valid),
        .press     (press),
        .multi_key (multi_key)
    );

    always @(negedge clk) begin
        if (key_valid === 1'b1) begin
            exp_t e;
            kv_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL kv_unexpected: key_value=%0d multi_key=%b, no key expected", key_value, multi_key);
            end else begin
                e = exp_q.pop_front();
                if (key_value !== 4'(e.code) || multi_key !== e.multi) begin
                    errors++;
                    $display("FAIL kv_scoreboard: got key_value=%0d multi_key=%b, want %0d/%b",
                             key_value, multi_key, e.code, e.multi);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_col_enter(input logic [3:0] target);
        logic [3:0] prev;
        bit found;
        found = 0;
        prev  = col;
        for (int n = 0; n < 200 && !found; n++) begin
            @(negedge clk);
            if (col === target && prev !== target) found = 1;
            prev = col;
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wait_col: col=%b never entered %b", col, target);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (col !== 4'b1111) begin errors++; $display("FAIL reset_col: got %b want 1111", col); end
        checks++; if (press !== 1'b0) begin errors++; $display("FAIL reset_press: got %b want 0", press); end
        checks++; if (key_value !== 4'd0) begin errors++; $display("FAIL reset_key_value: got %0d want 0", key_value); end
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL reset_key_valid: got %b want 0", key_valid); end
        checks++; if (multi_key !== 1'b0) begin errors++; $display("FAIL reset_multi_key: got %b want 0", multi_key); end
        rst = 1'b0;
        for (int k = 0; k < 16; k++) begin
            logic [3:0] want;
            @(negedge clk);
            want = 4'b1111 ^ (4'b0001 << (k / SCAN_DWELL));
            checks++;
            if (col !== want) begin
                errors++;
                $display("FAIL scan_rotate[%0d]: col=%b want %b", k, col, want);
            end
        end
    endtask

    task automatic test_single_key();
        int n;
        int kv0;
        wait_col_enter(4'b1110);
        kv0 = kv_count;
        key_c = 2'd0; key_mask = 4'b0111; key_on = 1'b1;
        exp_q.push_back('{code: 12, multi: 1'b0});
        n = 0;
        while (key_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n < SCAN_DWELL + DEBOUNCE_CYCLES - 1 || n > SCAN_DWELL + DEBOUNCE_CYCLES + 1) begin
            errors++;
            $display("FAIL single_latency: key_valid after %0d clocks, want %0d +/-1", n, SCAN_DWELL + DEBOUNCE_CYCLES);
        end
        checks++; if (press !== 1'b1) begin errors++; $display("FAIL single_press: got %b want 1", press); end
        @(negedge clk);
        checks++; if (key_valid !== 1'b0) begin errors++; $display("FAIL single_strobe: key_valid=%b want 0", key_valid); end
        checks++; if (key_value !== 4'd12) begin errors++; $display("FAIL single_hold_value: got %0d want 12", key_value); end
        repeat (10) @(negedge clk);
        key_on = 1'b0;
        n = 0;
        while (press !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (n < RELEASE_CYCLES + 2 || n > RELEASE_CYCLES + 4) begin
            errors++;
            $display("FAIL single_release: press fell after %0d clocks, want %0d..%0d", n, RELEASE_CYCLES + 2, RELEASE_CYCLES + 4);
        end
        checks++; if (col !== 4'b1101) begin errors++; $display("FAIL single_resume_col: col=%b want 1101", col); end
        checks++; if (kv_count - kv0 != 1) begin errors++; $display("FAIL single_count: %0d key_valid pulses, want 1", kv_count - kv0); end
    endtask

    task automatic test_bounce();
        int  kv0;
        bit  press_seen;
        bit  saw_last_col;
        wait_col_enter(4'b1110);
        kv0 = kv_count;
        key_c = 2'd0; key_mask = 4'b0111; key_on = 1'b1;
        repeat (10) @(negedge clk);
        key_on = 1'b0;
        press_seen = 0; saw_last_col = 0;
        repeat (40) begin
            @(negedge clk);
            if (press !== 1'b0) press_seen = 1;
            if (col === 4'b0111) saw_last_col = 1;
        end
        checks++; if (kv_count != kv0) begin errors++; $display("FAIL bounce_valid: %0d key_valid pulses, want 0", kv_count - kv0); end
        checks++; if (press_seen) begin errors++; $display("FAIL bounce_press: press went high, want 0"); end
        checks++; if (!saw_last_col) begin errors++; $display("FAIL bounce_scan: col never reached 0111, last col=%b", col); end
    endtask

    task automatic test_multi_key();
        int n;
        int kv0;
        kv0 = kv_count;
        key_c = 2'd1; key_mask = 4'b0110; key_on = 1'b1;
        exp_q.push_back('{code: 1, multi: 1'b1});
        n = 0;
        while (key_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++; if (n >= 100) begin errors++; $display("FAIL multi_timeout: no key_valid within %0d clocks", n); end
        checks++; if (multi_key !== 1'b1) begin errors++; $display("FAIL multi_flag: got %b want 1", multi_key); end
        key_on = 1'b0;
        n = 0;
        while (press !== 1'b0 && n < 100) begin @(negedge clk); n++; end
        checks++; if (multi_key !== 1'b0) begin errors++; $display("FAIL multi_clear: got %b want 0 after release", multi_key); end
        checks++; if (kv_count - kv0 != 1) begin errors++; $display("FAIL multi_count: %0d key_valid pulses, want 1", kv_count - kv0); end
    endtask

    task automatic test_long_hold();
        int n;
        int kv0;
        kv0 = kv_count;
        key_c = 2'd2; key_mask = 4'b0111; key_on = 1'b1;
        for (int i = 0; i < LONG_HOLD_VALIDS; i++) exp_q.push_back('{code: 14, multi: 1'b0});
        n = 0;
        while (key_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++; if (n >= 100) begin errors++; $display("FAIL long_timeout: no first key_valid within %0d clocks", n); end
        repeat (3900) @(negedge clk);
        key_on = 1'b0;
        repeat (60) @(negedge clk);
        checks++;
        if (kv_count - kv0 != LONG_HOLD_VALIDS) begin
            errors++;
            $display("FAIL long_count: %0d key_valid pulses, want %0d", kv_count - kv0, LONG_HOLD_VALIDS);
        end
        checks++; if (press !== 1'b0) begin errors++; $display("FAIL long_release: press=%b want 0", press); end
    endtask

    task automatic test_reset_in_held();
        int n;
        int kv0;
        key_c = 2'd3; key_mask = 4'b1110; key_on = 1'b1;
        exp_q.push_back('{code: 3, multi: 1'b0});
        n = 0;
        while (key_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++; if (n >= 100) begin errors++; $display("FAIL rstheld_timeout: no key_valid within %0d clocks", n); end
        repeat (5) @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++; if (press !== 1'b0) begin errors++; $display("FAIL rstheld_press: got %b want 0 without clock", press); end
        checks++; if (col !== 4'b1111) begin errors++; $display("FAIL rstheld_col: got %b want 1111 without clock", col); end
        key_on = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        kv0 = kv_count;
        @(negedge clk);
        checks++; if (col !== 4'b1110) begin errors++; $display("FAIL rstheld_restart: col=%b want 1110", col); end
        repeat (40) @(negedge clk);
        checks++; if (kv_count != kv0) begin errors++; $display("FAIL rstheld_spurious: %0d key_valid pulses, want 0", kv_count - kv0); end
        checks++; if (press !== 1'b0) begin errors++; $display("FAIL rstheld_press_after: got %b want 0", press); end
    endtask

    initial begin
        test_reset();
        test_single_key();
        test_bounce();
        test_multi_key();
        test_long_hold();
        test_reset_in_held();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d expected key_valid never seen", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
